// File: rtl/des_round_key_sequencer.sv
// ---------------------------------------------------------------------------
// des_round_key_sequencer
// Captures a full DES/3DES round-key schedule into an internal bank and
// streams it one key per valid/ready handshake. Forward order (0..ROUNDS-1)
// is used for encryption and reverse order (ROUNDS-1..0) for decryption.
//
// Ports
//   clk, rst       : rising-edge clock, synchronous active-high reset
//   load           : capture round_keys_in into the bank (IDLE only)
//   round_keys_in  : schedule, round r at [(ROUNDS-1-r)*KEY_W +: KEY_W]
//   start, decrypt : begin a stream; decrypt selects reverse order
//   key_out        : current key (zero when key_valid=0)
//   key_round      : bank index of key_out (zero when key_valid=0)
//   key_valid      : key_out is valid
//   key_ready      : consumer accepts key_out this cycle
//   key_last       : key_out is the final key of the stream
//   busy           : stream in progress
//   done           : one-cycle pulse after the final transfer
// ---------------------------------------------------------------------------
module des_round_key_sequencer #(
    parameter int unsigned ROUNDS = 16,
    parameter int unsigned KEY_W  = 48,
    localparam int unsigned CNT_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [ROUNDS*KEY_W-1:0] round_keys_in,
    input  logic                    start,
    input  logic                    decrypt,
    output logic [KEY_W-1:0]        key_out,
    output logic [CNT_W-1:0]        key_round,
    output logic                    key_valid,
    input  logic                    key_ready,
    output logic                    key_last,
    output logic                    busy,
    output logic                    done
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ROUNDS - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic             mode_q, mode_d;
    logic             done_q, done_d;
    logic             bank_we;
    logic             is_last;
    logic [KEY_W-1:0] bank_q [ROUNDS];

    // Final key depends on direction: top of the bank forward, bottom reverse
    assign is_last = mode_q ? (idx_q == '0) : (idx_q == LAST_IDX);

    // Next-state and control decode
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        bank_we = 1'b0;
        case (state_q)
            IDLE: begin
                bank_we = load;
                if (start) begin
                    mode_d  = decrypt;
                    idx_d   = decrypt ? LAST_IDX : '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (key_ready) begin
                    if (is_last) begin
                        // Park the index at 0 so the idle state matches reset
                        state_d = IDLE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else if (mode_q) begin
                        idx_d = idx_q - CNT_W'(1);
                    end else begin
                        idx_d = idx_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    // Key bank; a load coinciding with start is visible to that stream
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < ROUNDS; r++) begin
                bank_q[r] <= '0;
            end
        end else if (bank_we) begin
            for (int unsigned r = 0; r < ROUNDS; r++) begin
                bank_q[r] <= round_keys_in[(ROUNDS-1-r)*KEY_W +: KEY_W];
            end
        end
    end

    // Outputs decoded from registered state only (no path from key_ready/start)
    assign key_valid = (state_q == STREAM);
    assign busy      = key_valid;
    assign key_out   = key_valid ? bank_q[idx_q] : '0;
    assign key_round = key_valid ? idx_q : '0;
    assign key_last  = key_valid && is_last;
    assign done      = done_q;

endmodule

// File: tb/tb_des_round_key_sequencer.sv
// ---------------------------------------------------------------------------
// Self-checking bench for des_round_key_sequencer: a 16x48 instance driven by
// directed and randomized streams against a key-list model, and a 4x8 instance
// checked against a constant vector table.
// ---------------------------------------------------------------------------
module tb_des_round_key_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // 16-round, 48-bit instance
    logic         rst, load, start, decrypt, key_ready;
    logic [767:0] keys_in;
    logic [47:0]  key_out;
    logic [3:0]   key_round;
    logic         key_valid, key_last, busy, done;

    des_round_key_sequencer #(.ROUNDS(16), .KEY_W(48)) dut16 (
        .clk(clk), .rst(rst), .load(load), .round_keys_in(keys_in),
        .start(start), .decrypt(decrypt), .key_out(key_out),
        .key_round(key_round), .key_valid(key_valid), .key_ready(key_ready),
        .key_last(key_last), .busy(busy), .done(done)
    );

    // 4-round, 8-bit instance
    logic        rst4, load4, start4, dec4, ready4;
    logic [31:0] keys4;
    logic [7:0]  key_out4;
    logic [1:0]  key_round4;
    logic        valid4, last4, busy4, done4;

    des_round_key_sequencer #(.ROUNDS(4), .KEY_W(8)) dut4 (
        .clk(clk), .rst(rst4), .load(load4), .round_keys_in(keys4),
        .start(start4), .decrypt(dec4), .key_out(key_out4),
        .key_round(key_round4), .key_valid(valid4), .key_ready(ready4),
        .key_last(last4), .busy(busy4), .done(done4)
    );

    // Reference model: the bank as a plain array of keys
    logic [47:0] mbank [16];
    bit          pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    typedef struct {
        bit         dec;
        logic [7:0] exp [4];
    } vec4_t;
    vec4_t tbl [2];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_idle16(input string tag);
        check({tag, "_valid"}, 64'(key_valid), 64'd0);
        check({tag, "_busy"},  64'(busy),      64'd0);
        check({tag, "_key"},   64'(key_out),   64'd0);
        check({tag, "_round"}, 64'(key_round), 64'd0);
        check({tag, "_last"},  64'(key_last),  64'd0);
    endtask

    function automatic logic [767:0] pack16();
        logic [767:0] v;
        for (int r = 0; r < 16; r++) v[(15-r)*48 +: 48] = mbank[r];
        return v;
    endfunction

    task automatic load16();
        @(negedge clk);
        keys_in = pack16();
        load    = 1'b1;
        @(negedge clk);
        load    = 1'b0;
    endtask

    // rmode: 0 = ready always high, 1 = fixed pattern, 2 = random
    task automatic stream16(input bit dec, input int rmode, input bit junk,
                            input bit do_load, input logic [767:0] new_keys);
        int k;
        int cyc;
        int exp_idx;
        bit rdy;
        @(negedge clk);
        start   = 1'b1;
        decrypt = dec;
        if (do_load) begin
            load    = 1'b1;
            keys_in = new_keys;
            for (int r = 0; r < 16; r++) mbank[r] = new_keys[(15-r)*48 +: 48];
        end
        @(negedge clk);
        start = 1'b0;
        load  = 1'b0;
        k     = 0;
        cyc   = 0;
        while (k < 16 && cyc < 200) begin
            exp_idx = dec ? 15 - k : k;
            check("s_valid", 64'(key_valid), 64'd1);
            check("s_busy",  64'(busy),      64'd1);
            check("s_round", 64'(key_round), 64'(exp_idx));
            check("s_key",   64'(key_out),   64'(mbank[exp_idx]));
            check("s_last",  64'(key_last),  64'(k == 15));
            check("s_done",  64'(done),      64'd0);
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = pat[cyc % 6];
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            key_ready = rdy;
            load      = 1'b0;
            start     = 1'b0;
            if (junk && cyc == 3) begin
                load    = 1'b1;
                keys_in = ~keys_in;
                start   = 1'b1;
                decrypt = ~dec;
            end
            @(negedge clk);
            if (rdy) k++;
            cyc++;
        end
        load  = 1'b0;
        start = 1'b0;
        checks++;
        if (k < 16) begin
            failures++;
            $display("FAIL stream_timeout: got %0d transfers expected 16", k);
        end
        key_ready = 1'b0;
        check("end_done", 64'(done), 64'd1);
        check_idle16("end");
        @(negedge clk);
        check("end_done_clear", 64'(done), 64'd0);
    endtask

    initial begin
        logic [767:0] rk;

        tbl[0].dec = 1'b0;
        tbl[0].exp = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        tbl[1].dec = 1'b1;
        tbl[1].exp = '{8'hA3, 8'hA2, 8'hA1, 8'hA0};

        rst = 1'b1; load = 1'b0; start = 1'b0; decrypt = 1'b0; key_ready = 1'b0;
        keys_in = '0;
        rst4 = 1'b1; load4 = 1'b0; start4 = 1'b0; dec4 = 1'b0; ready4 = 1'b0;
        keys4 = '0;
        for (int r = 0; r < 16; r++) mbank[r] = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rst4 = 1'b0;

        check_idle16("reset");
        check("reset_done", 64'(done), 64'd0);
        check("reset4_valid", 64'(valid4), 64'd0);
        check("reset4_done",  64'(done4),  64'd0);

        // Forward, reverse, backpressure, ignored commands
        for (int r = 0; r < 16; r++) mbank[r] = 48'(r);
        load16();
        stream16(1'b0, 0, 1'b0, 1'b0, '0);
        stream16(1'b1, 0, 1'b0, 1'b0, '0);
        stream16(1'b0, 1, 1'b0, 1'b0, '0);
        stream16(1'b0, 0, 1'b1, 1'b0, '0);
        stream16(1'b1, 0, 1'b0, 1'b0, '0);

        // load + start together, random keys, direction and backpressure
        for (int n = 0; n < 4; n++) begin
            for (int w = 0; w < 24; w++) rk[w*32 +: 32] = $urandom;
            stream16(1'($urandom_range(0, 1)), 2, 1'b0, 1'b1, rk);
        end

        // Reset after the 5th key aborts the stream and clears the bank
        @(negedge clk);
        start = 1'b1; decrypt = 1'b0;
        @(negedge clk);
        start = 1'b0; key_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("abort_round_before", 64'(key_round), 64'd5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; key_ready = 1'b0;
        check_idle16("abort");
        check("abort_done", 64'(done), 64'd0);
        @(negedge clk);
        check("abort_done_late", 64'(done), 64'd0);
        for (int r = 0; r < 16; r++) mbank[r] = '0;
        stream16(1'b0, 0, 1'b0, 1'b0, '0);

        // Small instance: table vectors, second start issued in the done cycle
        @(negedge clk);
        keys4 = 32'hA0A1A2A3;
        load4 = 1'b1;
        @(negedge clk);
        load4  = 1'b0;
        ready4 = 1'b1;
        start4 = 1'b1;
        dec4   = tbl[0].dec;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            start4 = 1'b0;
            for (int k = 0; k < 4; k++) begin
                check("t4_valid", 64'(valid4),     64'd1);
                check("t4_key",   64'(key_out4),   64'(tbl[i].exp[k]));
                check("t4_round", 64'(key_round4), 64'(tbl[i].dec ? 3 - k : k));
                check("t4_last",  64'(last4),      64'(k == 3));
                @(negedge clk);
            end
            check("t4_done", 64'(done4),  64'd1);
            check("t4_busy", 64'(busy4),  64'd0);
            check("t4_key0", 64'(key_out4), 64'd0);
            if (i + 1 < 2) begin
                start4 = 1'b1;
                dec4   = tbl[i + 1].dec;
            end
        end
        @(negedge clk);
        check("t4_done_clear", 64'(done4), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
